// File: rtl/chimera_widemem_bypass_ctrl.sv
// Wide-memory bypass mode switch controller: drains outstanding AW/AR traffic,
// flips the bypass mode and holds new requests off for a settle window.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | traffic flows, mode matches request
// DRAIN  | new AW/AR stalled, waiting for wr_cnt and rd_cnt to reach 0
// SWITCH | one cycle, mode register takes the requested value
// SETTLE | new AW/AR still stalled for SettleCycles cycles
module chimera_widemem_bypass_ctrl #(
   parameter int   MaxOutstanding = 16,
   parameter int   SettleCycles   = 4,
   parameter logic BypassRst      = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic bypass_req_i,
   input  logic aw_valid_i,
   input  logic ar_valid_i,
   input  logic aw_ready_i,
   input  logic ar_ready_i,
   output logic aw_valid_o,
   output logic ar_valid_o,
   output logic aw_ready_o,
   output logic ar_ready_o,
   input  logic b_valid_i,
   input  logic b_ready_i,
   input  logic r_valid_i,
   input  logic r_ready_i,
   input  logic r_last_i,
   output logic widemem_bypass_o,
   output logic busy_o,
   output logic err_o
);

   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam int SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [SetW-1:0] SetLoad = SetW'(SettleCycles - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_t;

   state_t          state;
   logic [SetW-1:0] settle_cnt;
   logic [CntW-1:0] wr_cnt, rd_cnt, wr_nxt, rd_nxt;
   logic            wr_uflow, rd_uflow;
   logic            stall_aw, stall_ar;
   logic            aw_inc, ar_inc, wr_dec, rd_dec;

   assign stall_aw   = (state != IDLE) || (wr_cnt == CntMax);
   assign stall_ar   = (state != IDLE) || (rd_cnt == CntMax);
   assign aw_valid_o = aw_valid_i & ~stall_aw;
   assign aw_ready_o = aw_ready_i & ~stall_aw;
   assign ar_valid_o = ar_valid_i & ~stall_ar;
   assign ar_ready_o = ar_ready_i & ~stall_ar;

   assign aw_inc = aw_valid_o & aw_ready_i;
   assign ar_inc = ar_valid_o & ar_ready_i;
   assign wr_dec = b_valid_i & b_ready_i;
   assign rd_dec = r_valid_i & r_ready_i & r_last_i;

   // A decrement at zero holds the count and flags underflow instead of wrapping.
   always_comb begin
      wr_nxt   = wr_cnt;
      wr_uflow = 1'b0;
      if (aw_inc && !wr_dec) begin
         wr_nxt = wr_cnt + 1'b1;
      end else if (wr_dec && !aw_inc) begin
         if (wr_cnt == '0) wr_uflow = 1'b1;
         else              wr_nxt   = wr_cnt - 1'b1;
      end
   end

   always_comb begin
      rd_nxt   = rd_cnt;
      rd_uflow = 1'b0;
      if (ar_inc && !rd_dec) begin
         rd_nxt = rd_cnt + 1'b1;
      end else if (rd_dec && !ar_inc) begin
         if (rd_cnt == '0) rd_uflow = 1'b1;
         else              rd_nxt   = rd_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         err_o  <= 1'b0;
      end else begin
         wr_cnt <= wr_nxt;
         rd_cnt <= rd_nxt;
         if (wr_uflow || rd_uflow) err_o <= 1'b1;
      end
   end

   // DRAIN looks at next-cycle counts so a final response lets SWITCH follow directly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         settle_cnt       <= '0;
         widemem_bypass_o <= BypassRst;
         busy_o           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bypass_req_i != widemem_bypass_o) begin
                  state  <= DRAIN;
                  busy_o <= 1'b1;
               end
            end
            DRAIN: begin
               if (bypass_req_i == widemem_bypass_o) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (wr_nxt == '0 && rd_nxt == '0) begin
                  state <= SWITCH;
               end
            end
            SWITCH: begin
               widemem_bypass_o <= bypass_req_i;
               settle_cnt       <= SetLoad;
               state            <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
